// File: rtl/cpu_clock_controller_if.sv
// Front-panel / CPU side signals of the simplex8 clock controller.
// The master modport is the panel/CPU side and the slave modport is the controller.
interface cpu_clock_controller_if #(
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic [DIV_W-1:0]   divBy;
    logic               run_btn;
    logic               halt_btn;
    logic               step_btn;
    logic               cpu_halt;
    logic               burst_btn;
    logic [BURST_W-1:0] burst_len;
    logic               tick;
    logic               running;
    logic [CNT_W-1:0]   tick_count;

    modport master (
        output divBy, run_btn, halt_btn, step_btn, cpu_halt, burst_btn, burst_len,
        input  tick, running, tick_count
    );

    modport slave (
        input  divBy, run_btn, halt_btn, step_btn, cpu_halt, burst_btn, burst_len,
        output tick, running, tick_count
    );
endinterface

// File: rtl/cpu_clock_controller.sv
// Run/halt/step sequencer producing a one-cycle CPU clock-enable from a programmable divider.
// Define CPU_CLKCTL_BURST_EN to add the BURST state (run exactly burst_len ticks, then halt).
module cpu_clock_controller #(
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input logic                   clkin,
    input logic                   reset,
    cpu_clock_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
`ifdef CPU_CLKCTL_BURST_EN
        , ST_BURST = 2'd3
`endif
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   count;
    logic [DIV_W-1:0]   div_active;
    logic               tick_r;
    logic               running_r;
    logic [CNT_W-1:0]   tick_count_r;
    logic               terminal;
    logic               start_ok;

`ifdef CPU_CLKCTL_BURST_EN
    logic [BURST_W-1:0] remaining;
`else
    logic               unused_burst;
    assign unused_burst = ^{bus.burst_btn, bus.burst_len};
`endif

    assign terminal = (count == div_active);
    // Starting needs no halt request; run_btn outranks burst_btn, which outranks step_btn.
    assign start_ok = !bus.halt_btn && !bus.cpu_halt;

    assign bus.tick       = tick_r;
    assign bus.running    = running_r;
    assign bus.tick_count = tick_count_r;

    // NOTE: every register here uses <= so all branches see the pre-edge values of state/count.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state        <= ST_HALTED;
            count        <= '0;
            div_active   <= bus.divBy;
            tick_r       <= 1'b0;
            running_r    <= 1'b0;
            tick_count_r <= '0;
`ifdef CPU_CLKCTL_BURST_EN
            remaining    <= '0;
`endif
        end else begin
            tick_count_r <= tick_count_r + CNT_W'(tick_r);
            tick_r       <= 1'b0;

            case (state)
                ST_HALTED: begin
                    count <= '0;
                    if (start_ok && bus.run_btn) begin
                        // The start edge is the divider's count-0 cycle, so the first tick
                        // lands divBy+1 cycles after the button.
                        state      <= ST_RUNNING;
                        running_r  <= 1'b1;
                        div_active <= bus.divBy;
                        if (bus.divBy == '0) tick_r <= 1'b1;
                        else                 count  <= DIV_W'(1);
                    end
`ifdef CPU_CLKCTL_BURST_EN
                    else if (start_ok && bus.burst_btn && bus.burst_len != '0) begin
                        div_active <= bus.divBy;
                        if (bus.divBy == '0) begin
                            tick_r    <= 1'b1;
                            remaining <= bus.burst_len - BURST_W'(1);
                            if (bus.burst_len != BURST_W'(1)) begin
                                state     <= ST_BURST;
                                running_r <= 1'b1;
                            end
                        end else begin
                            count     <= DIV_W'(1);
                            remaining <= bus.burst_len;
                            state     <= ST_BURST;
                            running_r <= 1'b1;
                        end
                    end
`endif
                    else if (!bus.halt_btn && bus.step_btn) begin
                        state  <= ST_STEP;
                        tick_r <= 1'b1;
                    end
                end

                ST_STEP: state <= ST_HALTED;

                default: begin
                    if (bus.halt_btn || bus.cpu_halt) begin
                        // Abort wins over a coincident terminal count: that tick is dropped.
                        state     <= ST_HALTED;
                        running_r <= 1'b0;
                        count     <= '0;
                    end else begin
                        if (terminal) begin
                            count      <= '0;
                            tick_r     <= 1'b1;
                            div_active <= bus.divBy;
                        end else begin
                            count <= count + DIV_W'(1);
                        end
`ifdef CPU_CLKCTL_BURST_EN
                        if (state == ST_BURST) begin
                            if (bus.run_btn) begin
                                state <= ST_RUNNING;
                            end else if (terminal) begin
                                remaining <= remaining - BURST_W'(1);
                                if (remaining == BURST_W'(1)) begin
                                    state     <= ST_HALTED;
                                    running_r <= 1'b0;
                                end
                            end
                        end
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller; cycle c is the interval after the c-th posedge.
// Outputs are checked and inputs driven 1 ns after each rising edge.
module tb_cpu_clock_controller;
    logic clkin = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    cpu_clock_controller_if #(.DIV_W(26), .CNT_W(16), .BURST_W(8)) bus ();

    cpu_clock_controller #(.DIV_W(26), .CNT_W(16), .BURST_W(8)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clkin);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.divBy     = 26'd3;
        bus.run_btn   = 1'b0;
        bus.halt_btn  = 1'b0;
        bus.step_btn  = 1'b0;
        bus.cpu_halt  = 1'b0;
        bus.burst_btn = 1'b0;
        bus.burst_len = 8'd0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_count", 32'(bus.tick_count), 32'd0);

        // 1: divBy=3, run at c0 -> ticks at c4, c8, c12
        bus.run_btn = 1'b1;
        next_cycle();
        bus.run_btn = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("t1_tick_c%0d", c), 32'(bus.tick), 32'((c % 4) == 0));
            check($sformatf("t1_running_c%0d", c), 32'(bus.running), 32'd1);
            next_cycle();
        end
        check("t1_tick_count", 32'(bus.tick_count), 32'd3);
        bus.halt_btn = 1'b1;
        next_cycle();
        bus.halt_btn = 1'b0;
        check("t1_halt_running", 32'(bus.running), 32'd0);
        check("t1_halt_tick", 32'(bus.tick), 32'd0);

        // 2: step at c0 and c5 -> ticks at c1 and c6 only
        for (int c = 0; c <= 7; c++) begin
            check($sformatf("t2_tick_c%0d", c), 32'(bus.tick), 32'(c == 1 || c == 6));
            check($sformatf("t2_running_c%0d", c), 32'(bus.running), 32'd0);
            bus.step_btn = (c == 0 || c == 5);
            next_cycle();
        end
        bus.step_btn = 1'b0;
        check("t2_tick_count", 32'(bus.tick_count), 32'd5);

        // 3: divBy=9, changed to 1 at c3 -> ticks at c10, then every 2 cycles
        bus.divBy   = 26'd9;
        bus.run_btn = 1'b1;
        next_cycle();
        bus.run_btn = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) bus.divBy = 26'd1;
            check($sformatf("t3_tick_c%0d", c), 32'(bus.tick),
                  32'(c == 10 || c == 12 || c == 14 || c == 16));
            bus.halt_btn = (c == 16);
            next_cycle();
        end
        bus.halt_btn = 1'b0;
        check("t3_halt_tick", 32'(bus.tick), 32'd0);
        check("t3_halt_running", 32'(bus.running), 32'd0);
        check("t3_tick_count", 32'(bus.tick_count), 32'd9);

        // 4: divBy=0 ticks every cycle; cpu_halt stops it, blocks run, allows step
        bus.divBy   = 26'd0;
        bus.run_btn = 1'b1;
        next_cycle();
        bus.run_btn = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("t4_tick_c%0d", c), 32'(bus.tick), 32'd1);
            next_cycle();
            if (c == 3) bus.cpu_halt = 1'b1;
        end
        check("t4_cpuhalt_tick", 32'(bus.tick), 32'd0);
        check("t4_cpuhalt_running", 32'(bus.running), 32'd0);
        bus.run_btn = 1'b1;
        next_cycle();
        bus.run_btn = 1'b0;
        check("t4_run_ignored_running", 32'(bus.running), 32'd0);
        check("t4_run_ignored_tick", 32'(bus.tick), 32'd0);
        bus.step_btn = 1'b1;
        next_cycle();
        bus.step_btn = 1'b0;
        check("t4_step_tick", 32'(bus.tick), 32'd1);
        check("t4_step_running", 32'(bus.running), 32'd0);
        next_cycle();
        check("t4_step_done", 32'(bus.tick), 32'd0);
        bus.cpu_halt = 1'b0;
        next_cycle();
        check("t4_tick_count", 32'(bus.tick_count), 32'd14);

        // 5: halt_btn on the terminal-count cycle drops the tick; reset mid-run clears all
        bus.divBy   = 26'd2;
        bus.run_btn = 1'b1;
        next_cycle();
        bus.run_btn = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("t5_tick_c%0d", c), 32'(bus.tick), 32'(c == 3));
            check($sformatf("t5_running_c%0d", c), 32'(bus.running), 32'(c <= 5));
            bus.halt_btn = (c == 5);
            next_cycle();
        end
        bus.halt_btn = 1'b0;
        check("t5_tick_count", 32'(bus.tick_count), 32'd15);
        bus.run_btn = 1'b1;
        next_cycle();
        bus.run_btn = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("t5_reset_tick", 32'(bus.tick), 32'd0);
        check("t5_reset_running", 32'(bus.running), 32'd0);
        check("t5_reset_count", 32'(bus.tick_count), 32'd0);
        next_cycle();
        check("t5_after_reset_tick", 32'(bus.tick), 32'd0);

`ifdef CPU_CLKCTL_BURST_EN
        // 6: burst of 3 at divBy=1 -> ticks at c2, c4, c6 then HALTED; burst_len=0 ignored
        bus.divBy     = 26'd1;
        bus.burst_len = 8'd3;
        bus.burst_btn = 1'b1;
        next_cycle();
        bus.burst_btn = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("t6_tick_c%0d", c), 32'(bus.tick), 32'(c == 2 || c == 4 || c == 6));
            check($sformatf("t6_running_c%0d", c), 32'(bus.running), 32'(c <= 5));
            next_cycle();
        end
        check("t6_tick_count", 32'(bus.tick_count), 32'd3);
        bus.burst_len = 8'd0;
`else
        // Without the burst option the burst inputs must have no effect.
        bus.divBy     = 26'd1;
        bus.burst_len = 8'd3;
`endif
        bus.burst_btn = 1'b1;
        next_cycle();
        bus.burst_btn = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t6_ignored_tick_c%0d", c), 32'(bus.tick), 32'd0);
            check($sformatf("t6_ignored_running_c%0d", c), 32'(bus.running), 32'd0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
